// File: rtl/proc_pkg.sv
// Shared types and widths for the filter processor pipeline.
// Holds the Reg->Exe bundle, the stage FSM states and the bubble constant.
package proc_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 4;
    localparam int OP_W   = 4;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BUBBLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  ra;
        logic [REG_W-1:0]  rb;
        logic [REG_W-1:0]  robj;
        logic              re_a;
        logic              re_b;
        logic              we;
        logic              mem_we;
        logic              mem_re;
        logic [DATA_W-1:0] opa;
        logic [DATA_W-1:0] opb;
        logic [OP_W-1:0]   op;
    } reg_exe_t;

    function automatic reg_exe_t bubble();
        return '0;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance monitoring.
// Freeze (hold) wins over clear, clear wins over increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    input  logic             hold,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!hold) begin
            if (clr)
                cnt <= '0;
            else if (inc && !(&cnt))
                cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/reg_exe_pipe.sv
// Reg->Exe pipeline register with load-use bubble, memory hold,
// branch squash and a saturating bubble counter.
module reg_exe_pipe
    import proc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dec_valid,
    input  logic [REG_W-1:0]  dec_Ra,
    input  logic [REG_W-1:0]  dec_Rb,
    input  logic [REG_W-1:0]  dec_Robj,
    input  logic              dec_RE_A,
    input  logic              dec_RE_B,
    input  logic              dec_WE,
    input  logic              dec_mem_WE,
    input  logic              dec_mem_RE,
    input  logic [DATA_W-1:0] dec_opA,
    input  logic [DATA_W-1:0] dec_opB,
    input  logic [OP_W-1:0]   dec_op,
    input  logic              flush,
    input  logic              mem_busy,
    input  logic              cnt_clr,
    output logic [REG_W-1:0]  Ra_Reg_Exe,
    output logic [REG_W-1:0]  Rb_Reg_Exe,
    output logic [REG_W-1:0]  Robj_Reg_Exe,
    output logic              RE_A_Reg_Exe,
    output logic              RE_B_Reg_Exe,
    output logic              WE_Reg_Exe,
    output logic              mem_WE_Reg_Exe,
    output logic              mem_RE_Reg_Exe,
    output logic [DATA_W-1:0] opA_Reg_Exe,
    output logic [DATA_W-1:0] opB_Reg_Exe,
    output logic [OP_W-1:0]   op_Reg_Exe,
    output logic              valid_Reg_Exe,
    output logic              stall_F,
    output logic [CNT_W-1:0]  bubble_cnt
);

    reg_exe_t q, q_next;
    state_t   state, state_nxt;
    logic     flush_pend, flush_pend_nxt;
    logic     luse, kill, cnt_inc;

    // Forwarding cannot help when the load result is not yet read.
    assign luse = q.valid & q.mem_re & dec_valid &
                  ((dec_RE_A & (dec_Ra == q.robj)) |
                   (dec_RE_B & (dec_Rb == q.robj)));

    assign stall_F = mem_busy | (luse & ~flush);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            q          <= bubble();
            flush_pend <= 1'b0;
        end else begin
            state      <= state_nxt;
            q          <= q_next;
            flush_pend <= flush_pend_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN: begin
                if (mem_busy)
                    state_nxt = HOLD;
                else if (luse && !flush)
                    state_nxt = BUBBLE;
                else
                    state_nxt = RUN;
            end
            BUBBLE:  state_nxt = mem_busy ? HOLD : RUN;
            HOLD:    state_nxt = mem_busy ? HOLD : RUN;
            default: state_nxt = RUN;
        endcase
    end

    // A flush raised while held only exists in HOLD; replay it on release.
    assign kill = flush | (flush_pend & (state == HOLD));

    always_comb begin
        q_next         = q;
        flush_pend_nxt = flush_pend;
        cnt_inc        = 1'b0;
        if (mem_busy) begin
            if (flush)
                flush_pend_nxt = 1'b1;
        end else if (kill || luse) begin
            q_next         = bubble();
            flush_pend_nxt = 1'b0;
            cnt_inc        = 1'b1;
        end else if (!dec_valid) begin
            q_next = bubble();
        end else begin
            q_next.valid  = 1'b1;
            q_next.ra     = dec_Ra;
            q_next.rb     = dec_Rb;
            q_next.robj   = dec_Robj;
            q_next.re_a   = dec_RE_A;
            q_next.re_b   = dec_RE_B;
            q_next.we     = dec_WE;
            q_next.mem_we = dec_mem_WE;
            q_next.mem_re = dec_mem_RE;
            q_next.opa    = dec_opA;
            q_next.opb    = dec_opB;
            q_next.op     = dec_op;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cnt_inc),
        .clr   (cnt_clr),
        .hold  (mem_busy),
        .cnt   (bubble_cnt)
    );

    assign valid_Reg_Exe  = q.valid;
    assign Ra_Reg_Exe     = q.ra;
    assign Rb_Reg_Exe     = q.rb;
    assign Robj_Reg_Exe   = q.robj;
    assign RE_A_Reg_Exe   = q.re_a;
    assign RE_B_Reg_Exe   = q.re_b;
    assign WE_Reg_Exe     = q.we;
    assign mem_WE_Reg_Exe = q.mem_we;
    assign mem_RE_Reg_Exe = q.mem_re;
    assign opA_Reg_Exe    = q.opa;
    assign opB_Reg_Exe    = q.opb;
    assign op_Reg_Exe     = q.op;

endmodule
